// File: rtl/alu_cmd_issue_if.sv
// Handshake bundle between a command producer/result consumer and the
// alu_cmd_issue stage, including the operand/result path to the ALU.
// master: the side that issues commands, consumes results and returns alu_o.
// slave:  the issue stage itself.
interface alu_cmd_issue_if #(
  parameter int W     = 8,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
);
  // command side
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [W-1:0]           cmd_a;
  logic [W-1:0]           cmd_b;
  logic [OPW-1:0]         cmd_op;
  // ALU drive / return
  logic [W-1:0]           a;
  logic [W-1:0]           b;
  logic [OPW-1:0]         encode_op;
  logic [W-1:0]           alu_o;
  // result side
  logic                   res_valid;
  logic                   res_ready;
  logic [W-1:0]           res_data;
  logic [OPW-1:0]         res_op;
  // occupancy
  logic [$clog2(DEPTH):0] count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, alu_o,
    input  cmd_ready, a, b, encode_op, res_valid, res_data, res_op, count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, alu_o,
    output cmd_ready, a, b, encode_op, res_valid, res_data, res_op, count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command issue stage in front of the combinational ALU. Commands are queued
// in a small FIFO; the head entry drives the ALU and its output is captured
// into a result register with its own valid/ready handshake.
module alu_cmd_issue #(
  parameter int W     = 8,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_cmd_issue_if.slave bus
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // state
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_res_valid;
  logic [W-1:0]       r_res_data;
  logic [OPW-1:0]     r_res_op;

  // combinational
  logic               w_full;
  logic               w_empty;
  logic               w_cmd_ready;
  logic               w_push;
  logic               w_pop;
  logic [DEPTH*W-1:0]   w_slot_a;
  logic [DEPTH*W-1:0]   w_slot_b;
  logic [DEPTH*OPW-1:0] w_slot_op;
  logic [W-1:0]       w_head_a;
  logic [W-1:0]       w_head_b;
  logic [OPW-1:0]     w_head_op;

  // Full/empty come from the occupancy counter, never from pointer compare.
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  // No pass-through when full: a pop in the same cycle does not open a slot.
  assign w_cmd_ready = !reset && !w_full;
  assign w_push      = bus.cmd_valid && w_cmd_ready;
  // Pop whenever there is a head entry and the result register is free or
  // being emptied this cycle.
  assign w_pop       = !w_empty && (!r_res_valid || bus.res_ready);

  // Storage: one register set per slot. Slots carry no reset because an
  // empty FIFO masks the head outputs to zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [OPW-1:0] r_op;

    // Capture the pushed command into the slot selected by the write pointer.
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == PW'(gi))) begin
        r_a  <= bus.cmd_a;
        r_b  <= bus.cmd_b;
        r_op <= bus.cmd_op;
      end
    end

    assign w_slot_a[gi*W +: W]       = r_a;
    assign w_slot_b[gi*W +: W]       = r_b;
    assign w_slot_op[gi*OPW +: OPW]  = r_op;
  end

  // Head select: the rd_ptr entry drives the ALU combinationally, zero when empty.
  always_comb begin
    w_head_a  = '0;
    w_head_b  = '0;
    w_head_op = '0;
    if (!w_empty) begin
      w_head_a  = w_slot_a[int'(r_rd_ptr)*W +: W];
      w_head_b  = w_slot_b[int'(r_rd_ptr)*W +: W];
      w_head_op = w_slot_op[int'(r_rd_ptr)*OPW +: OPW];
    end
  end

  // Pointer advance; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: push-only increments, pop-only decrements, both hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result register: load on pop, clear valid on hand-off, hold during stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.alu_o;
      r_res_op    <= w_head_op;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.a         = w_head_a;
  assign bus.b         = w_head_b;
  assign bus.encode_op = w_head_op;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_op    = r_res_op;
  assign bus.count     = r_count;

endmodule
